bank_group_ctrl: RTL

Parametrised bank-group controller for the DDR emulation FSM layer. It decodes a compact command stream to `BANKSPERGROUP` banks and keeps a per-bank state machine and open-row register. It enforces per-bank (tRCD, tRAS, tRP, tRFC) and group-level (tCCD_L, tRRD_L) timing, accepting or rejecting each command. Accepted reads and writes are issued as registered strobes toward the bank data-path model.

---
 rtl/bank_group_ctrl.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/bank_group_ctrl.sv
// Bank-group controller: per-bank ACT/PRE/REF state machines with group tCCD_L/tRRD_L spacing.
// Define BG_PERF_CNT_EN to enable the act_count/rdwr_count performance counters.
module bank_group_ctrl #(
  parameter int ADDRWIDTH     = 17,
  parameter int COLS          = 1024,
  parameter int CADDRWIDTH    = $clog2(COLS),
  parameter int BANKSPERGROUP = 4,
  parameter int BAWIDTH       = $clog2(BANKSPERGROUP),
  parameter int TRCD          = 4,
  parameter int TRAS          = 10,
  parameter int TRP           = 4,
  parameter int TRFC          = 20,
  parameter int TCCD_L        = 2,
  parameter int TRRD_L        = 2,
  parameter int CNTW          = 6
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       halt,
  input  logic                       cmd_valid,
  input  logic [2:0]                 cmd,
  input  logic [BAWIDTH-1:0]         ba,
  input  logic [ADDRWIDTH-1:0]       row,
  input  logic [CADDRWIDTH-1:0]      column,
  output logic                       cmd_accept,
  output logic                       cmd_err,
  output logic [3*BANKSPERGROUP-1:0] bank_state,
  output logic [ADDRWIDTH-1:0]       open_row,
  output logic                       rd_stb,
  output logic                       wr_stb,
  output logic [BAWIDTH-1:0]         rw_bank,
  output logic [ADDRWIDTH-1:0]       rw_row,
  output logic [CADDRWIDTH-1:0]      rw_col,
  output logic [31:0]                act_count,
  output logic [31:0]                rdwr_count
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACTING = 3'd1,
    ST_OPEN   = 3'd2,
    ST_PRECH  = 3'd3,
    ST_REFR   = 3'd4
  } bstate_t;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_ACT  = 3'd1;
  localparam logic [2:0] OP_RD   = 3'd2;
  localparam logic [2:0] OP_WR   = 3'd3;
  localparam logic [2:0] OP_PRE  = 3'd4;
  localparam logic [2:0] OP_PREA = 3'd5;
  localparam logic [2:0] OP_REF  = 3'd6;

  localparam logic [CNTW-1:0] TRCD_LD = CNTW'((TRCD   > 1) ? TRCD   - 1 : 0);
  localparam logic [CNTW-1:0] TRAS_LD = CNTW'((TRAS   > 1) ? TRAS   - 1 : 0);
  localparam logic [CNTW-1:0] TRP_LD  = CNTW'((TRP    > 1) ? TRP    - 1 : 0);
  localparam logic [CNTW-1:0] TRFC_LD = CNTW'((TRFC   > 1) ? TRFC   - 1 : 0);
  localparam logic [CNTW-1:0] TCCD_LD = CNTW'((TCCD_L > 1) ? TCCD_L - 1 : 0);
  localparam logic [CNTW-1:0] TRRD_LD = CNTW'((TRRD_L > 1) ? TRRD_L - 1 : 0);

  function automatic logic [CNTW-1:0] dec_sat(input logic [CNTW-1:0] v);
    return (v == '0) ? v : v - CNTW'(1);
  endfunction

  bstate_t                st_q     [BANKSPERGROUP];
  bstate_t                st_d     [BANKSPERGROUP];
  logic [CNTW-1:0]        tcnt_q   [BANKSPERGROUP];
  logic [CNTW-1:0]        tcnt_d   [BANKSPERGROUP];
  logic [CNTW-1:0]        rascnt_q [BANKSPERGROUP];
  logic [CNTW-1:0]        rascnt_d [BANKSPERGROUP];
  logic [ADDRWIDTH-1:0]   row_q    [BANKSPERGROUP];
  logic [CNTW-1:0]        ccd_q, ccd_d, rrd_q, rrd_d;
  bstate_t                sel_st;
  logic                   legal, cmd_active, all_idle, prea_ok;
  logic                   rd_stb_p1, wr_stb_p1;
  logic [BAWIDTH-1:0]     rw_bank_p1;
  logic [ADDRWIDTH-1:0]   rw_row_p1;
  logic [CADDRWIDTH-1:0]  rw_col_p1;

  always_comb begin
    sel_st   = st_q[ba];
    all_idle = 1'b1;
    prea_ok  = 1'b1;
    for (int i = 0; i < BANKSPERGROUP; i++) begin
      if (st_q[i] != ST_IDLE) all_idle = 1'b0;
      if (st_q[i] == ST_OPEN && rascnt_q[i] != '0) prea_ok = 1'b0;
    end
    legal = 1'b0;
    case (cmd)
      OP_ACT:       legal = (sel_st == ST_IDLE) && (rrd_q == '0);
      OP_RD, OP_WR: legal = (sel_st == ST_OPEN) && (ccd_q == '0);
      OP_PRE:       legal = (sel_st == ST_IDLE) ||
                            ((sel_st == ST_OPEN) && (rascnt_q[ba] == '0));
      OP_PREA:      legal = prea_ok;
      OP_REF:       legal = all_idle;
      default:      legal = 1'b0;
    endcase
    cmd_active = cmd_valid && !halt && (cmd != OP_NOP);
    cmd_accept = cmd_active && legal;
    cmd_err    = cmd_active && !legal;
    open_row   = (sel_st == ST_OPEN) ? row_q[ba] : '0;
  end

  // Next state: timers expire one cycle early so the new state is visible at N+tX.
  always_comb begin
    st_d     = st_q;
    tcnt_d   = tcnt_q;
    rascnt_d = rascnt_q;
    ccd_d    = ccd_q;
    rrd_d    = rrd_q;
    if (!halt) begin
      ccd_d = dec_sat(ccd_q);
      rrd_d = dec_sat(rrd_q);
      for (int i = 0; i < BANKSPERGROUP; i++) begin
        tcnt_d[i] = dec_sat(tcnt_q[i]);
        case (st_q[i])
          ST_ACTING: begin
            rascnt_d[i] = dec_sat(rascnt_q[i]);
            if (tcnt_q[i] <= CNTW'(1)) st_d[i] = ST_OPEN;
          end
          ST_OPEN:  rascnt_d[i] = dec_sat(rascnt_q[i]);
          ST_PRECH,
          ST_REFR:  if (tcnt_q[i] <= CNTW'(1)) st_d[i] = ST_IDLE;
          default:  ;
        endcase
      end
    end
    if (cmd_accept) begin
      case (cmd)
        OP_ACT: begin
          st_d[ba]     = ST_ACTING;
          tcnt_d[ba]   = TRCD_LD;
          rascnt_d[ba] = TRAS_LD;
          rrd_d        = TRRD_LD;
        end
        OP_RD, OP_WR: ccd_d = TCCD_LD;
        OP_PRE: begin
          if (sel_st == ST_OPEN) begin
            st_d[ba]   = ST_PRECH;
            tcnt_d[ba] = TRP_LD;
          end
        end
        OP_PREA: begin
          for (int i = 0; i < BANKSPERGROUP; i++) begin
            if (st_q[i] == ST_OPEN) begin
              st_d[i]   = ST_PRECH;
              tcnt_d[i] = TRP_LD;
            end
          end
        end
        OP_REF: begin
          for (int i = 0; i < BANKSPERGROUP; i++) begin
            st_d[i]   = ST_REFR;
            tcnt_d[i] = TRFC_LD;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < BANKSPERGROUP; i++) begin
        st_q[i]     <= ST_IDLE;
        tcnt_q[i]   <= '0;
        rascnt_q[i] <= '0;
      end
      ccd_q <= '0;
      rrd_q <= '0;
    end else begin
      st_q     <= st_d;
      tcnt_q   <= tcnt_d;
      rascnt_q <= rascnt_d;
      ccd_q    <= ccd_d;
      rrd_q    <= rrd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (cmd_accept && cmd == OP_ACT) row_q[ba] <= row;
  end

  // Stage p1: strobe register toward the bank data-path model.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_stb_p1  <= 1'b0;
      wr_stb_p1  <= 1'b0;
      rw_bank_p1 <= '0;
      rw_row_p1  <= '0;
      rw_col_p1  <= '0;
    end else begin
      rd_stb_p1 <= cmd_accept && (cmd == OP_RD);
      wr_stb_p1 <= cmd_accept && (cmd == OP_WR);
      if (cmd_accept && (cmd == OP_RD || cmd == OP_WR)) begin
        rw_bank_p1 <= ba;
        rw_row_p1  <= row_q[ba];
        rw_col_p1  <= column;
      end
    end
  end

  assign rd_stb  = rd_stb_p1;
  assign wr_stb  = wr_stb_p1;
  assign rw_bank = rw_bank_p1;
  assign rw_row  = rw_row_p1;
  assign rw_col  = rw_col_p1;

  always_comb begin
    bank_state = '0;
    for (int i = 0; i < BANKSPERGROUP; i++) bank_state[3*i +: 3] = st_q[i];
  end

`ifdef BG_PERF_CNT_EN
  logic [31:0] act_cnt_q, rdwr_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      act_cnt_q  <= '0;
      rdwr_cnt_q <= '0;
    end else if (cmd_accept) begin
      if (cmd == OP_ACT)                  act_cnt_q  <= act_cnt_q + 32'd1;
      if (cmd == OP_RD || cmd == OP_WR)   rdwr_cnt_q <= rdwr_cnt_q + 32'd1;
    end
  end

  assign act_count  = act_cnt_q;
  assign rdwr_count = rdwr_cnt_q;
`else
  assign act_count  = '0;
  assign rdwr_count = '0;
`endif

endmodule
